// File: rtl/sincos_pkg.sv
// Shared constants, state encoding and phase-wrap helpers for sincos users.
// Phases are signed Q3.13 radians kept in [-pi, pi).
package sincos_pkg;

    localparam int PHASE_W = 16;

    localparam logic signed [PHASE_W-1:0] PI_POS = 16'sh6488;
    localparam logic signed [PHASE_W-1:0] PI_NEG = 16'sh9B78;
    localparam logic signed [PHASE_W:0]   TWO_PI = 17'sd51472;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } sweep_state_t;

    function automatic logic [PHASE_W-1:0] phase_wrap_add(
        input logic [PHASE_W-1:0] p,
        input logic [PHASE_W-1:0] inc
    );
        logic signed [PHASE_W:0] s;
        logic signed [PHASE_W:0] hi;
        logic signed [PHASE_W:0] lo;
        hi = $signed({PI_POS[PHASE_W-1], PI_POS});
        lo = $signed({PI_NEG[PHASE_W-1], PI_NEG});
        s  = $signed({p[PHASE_W-1], p}) + $signed({inc[PHASE_W-1], inc});
        if (s >= hi) begin
            s = s - TWO_PI;
        end else if (s < lo) begin
            s = s + TWO_PI;
        end
        return s[PHASE_W-1:0];
    endfunction

    // One step of at most pi from an in-range phase stays within one wrap.
    function automatic logic cfg_valid(
        input logic [PHASE_W-1:0] start_phase,
        input logic [PHASE_W-1:0] inc
    );
        logic signed [PHASE_W-1:0] sp;
        logic signed [PHASE_W-1:0] si;
        sp = $signed(start_phase);
        si = $signed(inc);
        return (sp >= PI_NEG) && (sp < PI_POS) &&
               (si >= PI_NEG) && (si <= PI_POS);
    endfunction

endpackage

// File: rtl/sincos_phase_acc.sv
// Load/step phase accumulator with wrap into [-pi, pi).
// The increment is captured on load so the step path needs no external hold.
module sincos_phase_acc
    import sincos_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PHASE_W-1:0] init,
    input  logic [PHASE_W-1:0] inc,
    input  logic               step,
    output logic [PHASE_W-1:0] value
);

    logic [PHASE_W-1:0] inc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            inc_q <= '0;
        end else if (load) begin
            value <= init;
            inc_q <= inc;
        end else if (step) begin
            value <= phase_wrap_add(value, inc_q);
        end
    end

endmodule

// File: rtl/sincos_sweep_ctrl.sv
// Phase-sweep sequencer in front of the pipelined sincos CORDIC core.
// Issues N phases back to back, tags the returned samples, bounds the drain.
module sincos_sweep_ctrl
    import sincos_pkg::*;
#(
    parameter int NUM_W          = 16,
    parameter int SINCOS_LATENCY = 18,
    parameter int TIMEOUT_MARGIN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [PHASE_W-1:0] cfg_start_phase,
    input  logic [PHASE_W-1:0] cfg_phase_inc,
    input  logic [NUM_W-1:0]   cfg_num_samples,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_tvalid,
    input  logic               sincos_tvalid,
    input  logic [PHASE_W-1:0] cos_in,
    input  logic [PHASE_W-1:0] sin_in,
    output logic               out_tvalid,
    output logic [PHASE_W-1:0] out_cos,
    output logic [PHASE_W-1:0] out_sin,
    output logic [NUM_W-1:0]   out_index,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               cfg_err
);

    localparam int DRAIN_LIMIT = SINCOS_LATENCY + TIMEOUT_MARGIN;
    localparam int TW          = $clog2(DRAIN_LIMIT + 1);
    // Entry cycle and the DONE cycle both count toward the drain window.
    localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_LIMIT - 2);

    sweep_state_t     state;
    logic [NUM_W-1:0] num_q;
    logic [NUM_W-1:0] iss_cnt;
    logic [NUM_W-1:0] rx_count;
    logic [TW-1:0]    timer;

    logic active;
    logic cfg_ok;
    logic go;
    logic load;
    logic step;
    logic rx_take;
    logic rx_done;

    assign active  = (state == ST_SWEEP) || (state == ST_DRAIN);
    assign cfg_ok  = cfg_valid(cfg_start_phase, cfg_phase_inc);
    assign go      = (state == ST_IDLE) && start && !abort;
    assign load    = go && cfg_ok && (cfg_num_samples != '0);
    assign step    = (state == ST_SWEEP) && !abort && (iss_cnt != num_q);
    assign rx_take = active && !abort && sincos_tvalid && (rx_count != num_q);
    assign rx_done = (rx_count == num_q) ||
                     (rx_take && (rx_count == num_q - NUM_W'(1)));

    sincos_phase_acc u_acc (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .init  (cfg_start_phase),
        .inc   (cfg_phase_inc),
        .step  (step),
        .value (phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            num_q        <= '0;
            iss_cnt      <= '0;
            rx_count     <= '0;
            timer        <= '0;
            phase_tvalid <= 1'b0;
            out_tvalid   <= 1'b0;
            out_cos      <= '0;
            out_sin      <= '0;
            out_index    <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            out_tvalid <= 1'b0;
            if (rx_take) begin
                out_tvalid <= 1'b1;
                out_cos    <= cos_in;
                out_sin    <= sin_in;
                out_index  <= rx_count;
                out_last   <= (rx_count == num_q - NUM_W'(1));
                rx_count   <= rx_count + NUM_W'(1);
            end
            unique case (state)
                ST_IDLE: begin
                    if (go && !cfg_ok) begin
                        cfg_err <= 1'b1;
                    end else if (go) begin
                        num_q    <= cfg_num_samples;
                        iss_cnt  <= NUM_W'(1);
                        rx_count <= '0;
                        timer    <= '0;
                        timeout  <= 1'b0;
                        if (cfg_num_samples == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state        <= ST_SWEEP;
                            phase_tvalid <= 1'b1;
                            busy         <= 1'b1;
                        end
                    end
                end
                ST_SWEEP: begin
                    if (abort) begin
                        state        <= ST_IDLE;
                        phase_tvalid <= 1'b0;
                        busy         <= 1'b0;
                    end else if (iss_cnt == num_q) begin
                        state        <= ST_DRAIN;
                        phase_tvalid <= 1'b0;
                        timer        <= '0;
                    end else begin
                        iss_cnt <= iss_cnt + NUM_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Completion is checked before expiry so a tie is a clean finish.
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (rx_done) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                    end else if (timer == DRAIN_LAST) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sincos_sweep_ctrl.md
Name: sincos_sweep_ctrl

Overview:
Sequencer that drives the pipelined `sincos` CORDIC core through a programmed phase sweep. It issues one phase per cycle from a configured start phase and increment, wrapping into [-pi, pi). It counts and tags the returned cos/sin samples, then reports completion or a drain timeout. It sits between the control/register interface and `sincos`, replacing free-running bench stimulus in the system.

Parameters:
NUM_W, 16, width of sample-count config and index outputs
SINCOS_LATENCY, 18, pipeline depth of `sincos` in cycles; sets drain timeout
TIMEOUT_MARGIN, 4, extra drain cycles allowed beyond SINCOS_LATENCY

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle sweep request, sampled in IDLE only
abort  in  1  single-cycle cancel
cfg_start_phase  in  16  signed Q3.13 first phase
cfg_phase_inc  in  16  signed Q3.13 per-sample increment
cfg_num_samples  in  NUM_W  samples to issue
phase  out  16  to `sincos` phase
phase_tvalid  out  1  to `sincos` phase_tvalid
sincos_tvalid  in  1  from `sincos`
cos_in  in  16  from `sincos` cos
sin_in  in  16  from `sincos` sin
out_tvalid  out  1  result valid
out_cos  out  16  registered cos
out_sin  out  16  registered sin
out_index  out  NUM_W  result index, 0-based
out_last  out  1  marks final result of sweep
busy  out  1  high in SWEEP/DRAIN
done  out  1  one-cycle completion pulse
timeout  out  1  sticky; set if drain expired, cleared on accepted start
cfg_err  out  1  one-cycle pulse on rejected start

Behaviour:
- All outputs are registered. Reset values: phase=0, phase_tvalid=0, out_*=0, busy=0, done=0, timeout=0, cfg_err=0, state=IDLE.
- Constants: PI_POS=0x6488 (25736), PI_NEG=0x9B78 (-25736), TWO_PI=51472 (17-bit).
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - start=1 with abort=1 → ignored.
  - start=1 with cfg_start_phase outside [PI_NEG, PI_POS) or |cfg_phase_inc| > PI_POS → cfg_err pulse next cycle; stay IDLE.
  - start=1 with cfg_num_samples=0 → DONE next cycle; no phase issued.
  - Otherwise latch config, clear counters and timeout, → SWEEP.
- SWEEP: phase_tvalid=1 for exactly N consecutive cycles. The first issued phase is cfg_start_phase, on the cycle after start.
- Phase update uses 17-bit signed next = phase + inc:
  - if next ≥ PI_POS, subtract TWO_PI;
  - if next < PI_NEG, add TWO_PI;
  - result always lies in [PI_NEG, PI_POS).
- After the Nth issue → DRAIN; phase_tvalid=0 and phase holds its last value.
- Receive path, in SWEEP/DRAIN only:
  - each sincos_tvalid → out_tvalid=1 one cycle later, with cos/sin registered and out_index = rx_count;
  - rx_count increments;
  - out_last=1 when rx_count = N-1.
  - sincos_tvalid in IDLE/DONE is discarded.
- DRAIN:
  - timer counts cycles from entry.
  - rx_count reaching N → DONE.
  - timer reaching SINCOS_LATENCY+TIMEOUT_MARGIN first → timeout=1, → DONE.
  - If the last result and the expiry occur in the same cycle, completion wins (timeout stays 0).
- DONE: done=1 for one cycle, busy=0, → IDLE.
- abort in SWEEP/DRAIN:
  - next cycle state=IDLE, phase_tvalid=0, busy=0;
  - no done pulse;
  - late results are discarded.
- start while busy is ignored.
- rst mid-sweep: all state returns to reset values on the next edge.

Decomposition:
- Package `sincos_pkg`: PHASE_W=16, PI_POS, PI_NEG, TWO_PI, and the state enum, shared with future `sincos` users.
- Sub-module `sincos_phase_acc`: load/step wrap accumulator (load, step, value), reusable for NCO work.

Test Plan:
- start_phase=0, inc=256, N=4 → phase 0,256,512,768 on 4 consecutive cycles; out_index 0..3; out_last on index 3; done once; timeout=0.
- Positive wrap: start=0x6400, inc=256, N=3 → 0x6400, 0x9BF0 (-25616), 0x9CF0.
- Negative wrap: start=0x9C00 (-25600), inc=-256, N=2 → 0x9C00, 0x6410 (25616).
- Stalled sincos_tvalid after 2 of 4 results → timeout=1 and done exactly SINCOS_LATENCY+4 cycles after DRAIN entry. The next valid start clears timeout.
- Config rejection:
  - start_phase=0x6488 → cfg_err pulse, busy stays 0.
  - inc=0x7000 → cfg_err pulse.
  - N=0 → done 2 cycles after start, no phase_tvalid.
- abort on 3rd SWEEP cycle of N=8 → phase_tvalid low next cycle, no done. Subsequent sincos_tvalid produces no out_tvalid. A new start is accepted immediately.
